// File: rtl/addsub32_seq_pkg.sv
// Shared definitions for the chunked add/subtract path: state encodings,
// default widths and the flag bit layout reused by the ALU result mux.
package addsub32_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  // state | meaning
  // IDLE  | ready for operands, last result held on the outputs
  // CALC  | one CHUNK-wide slice added per clock, carry rippled through a register
  // DONE  | result valid, waiting for the consumer
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Flag vector layout {C,V,Z,N}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic z, input logic n);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/addsub32_seq_addc_chunk.sv
// Combinational W-bit adder slice with carry in and carry out. The top
// instantiates one of these and reuses it for every chunk of the operands.
module addc_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] total;

  // Widen by one bit so the carry out falls out of the addition.
  always_comb begin
    total = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
  end

  assign s_o  = total[W-1:0];
  assign co_o = total[W];

endmodule

// File: rtl/addsub32_seq.sv
// Multi-cycle adder for the ALU add/subtract path. Operands are latched on
// acceptance, then added one CHUNK-wide slice per clock through a single
// shared adder slice; the sum and C/V/Z/N flags are registered on the last
// slice and presented with a valid/ready handshake.
module addsub32_seq
  import addsub32_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_x,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [3:0]       flags_q, flags_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_co;

  // Select the slice of the latched operands addressed by the chunk index.
  always_comb begin
    chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b = b_q[idx_q*CHUNK +: CHUNK];
  end

  addc_chunk #(.W(CHUNK)) u_addc_chunk (
    .a_i  (chunk_a),
    .b_i  (chunk_b),
    .ci_i (carry_q),
    .s_o  (chunk_s),
    .co_o (chunk_co)
  );

  // Next-state logic: accept in IDLE, ripple one chunk per CALC cycle,
  // publish sum and flags on the last chunk, release on out_ready.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_x;
          carry_d = cin;
          idx_d   = '0;
          psum_d  = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        psum_d[idx_q*CHUNK +: CHUNK] = chunk_s;
        carry_d = chunk_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // psum_d now holds the completed sum including this last slice.
          idx_d   = '0;
          sum_d   = psum_d;
          flags_d = pack_flags(chunk_co,
                               (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (psum_d[WIDTH-1] != a_q[WIDTH-1]),
                               (psum_d == '0),
                               psum_d[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign c_flag    = flags_q[FLAG_C];
  assign v_flag    = flags_q[FLAG_V];
  assign z_flag    = flags_q[FLAG_Z];
  assign n_flag    = flags_q[FLAG_N];

endmodule

// File: tb/tb_addsub32_seq.sv
// Scoreboard bench for addsub32_seq: accepted operands push an expected
// result computed with plain integer arithmetic; a monitor pops and compares
// on every output handshake and also checks latency and directed windows.
module tb_addsub32_seq;

  localparam int NCHUNK = 4;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b_x;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_flag, v_flag, z_flag, n_flag;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   chk_mode = 0;
  bit   rand_mode = 1'b0;
  logic prev_ov = 1'b0;

  addsub32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b_x       (b_x),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_flag    (c_flag),
    .v_flag    (v_flag),
    .z_flag    (z_flag),
    .n_flag    (n_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: unsigned sum gives result and carry, signed sum gives overflow.
  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ic);
    exp_t   e;
    longint us;
    longint ss;
    us = longint'(ia) + longint'(ib) + longint'(ic);
    ss = longint'($signed(ia)) + longint'($signed(ib)) + longint'(ic);
    e.sum   = us[31:0];
    e.flags = {us[32], (ss > 64'sd2147483647) || (ss < -64'sd2147483648),
               (us[31:0] == 32'd0), us[31]};
    e.acc   = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: scoreboard push/pop plus directed window checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      case (chk_mode)
        1: begin
          chk("hold_in_ready", in_ready, 0);
          chk("hold_out_valid", out_valid, 1);
          chk("hold_sum", sum, 32'h8000_0000);
          chk("hold_flags", {c_flag, v_flag, z_flag, n_flag}, 4'b0101);
        end
        2: begin
          chk("reset_out_valid", out_valid, 0);
          chk("reset_in_ready", in_ready, 1);
          chk("reset_sum", sum, 0);
          chk("reset_flags", {c_flag, v_flag, z_flag, n_flag}, 0);
        end
        3: chk("release_in_ready", in_ready, 1);
        default: ;
      endcase
      if (in_valid && in_ready) begin
        e = model(a, b_x, cin);
        e.acc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && !prev_ov) begin
        chk("pending_on_valid", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("latency", cyc - exp_q[0].acc, NCHUNK + 1);
      end
      if (out_valid && out_ready) begin
        chk("pending_on_pop", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", sum, e.sum);
          chk("flags_cvzn", {c_flag, v_flag, z_flag, n_flag}, e.flags);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic step_ready();
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic);
    int n;
    n = 0;
    @(posedge clk); #1;
    a = ia; b_x = ib; cin = ic; in_valid = 1'b1;
    step_ready();
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        $fatal(1, "accept timeout");
      end
      @(posedge clk); #1;
      step_ready();
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b_x = $urandom; cin = 1'($urandom_range(0, 1));
    step_ready();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_mode = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while (exp_q.size() != 0 || out_valid) begin
      n++;
      if (n > 300) begin
        $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
        $fatal(1, "drain timeout");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        k;
    int          n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b_x = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_mode = 2;
    @(negedge clk);
    @(posedge clk); #1 chk_mode = 0;

    // Directed cases from the test plan, consumer always ready.
    out_ready = 1'b1;
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(32'h0000_0005, ~32'h0000_0005, 1'b1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    issue(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(32'h0000_0003, ~32'h0000_0005, 1'b1);
    drain();

    // Randomized operations with random consumer backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 120; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h00FF_FFFF;
        default: ;
      endcase
      k  = 1'($urandom_range(0, 1));
      rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      issue(ra, rb ^ {32{k}}, k);
    end
    drain();

    // Backpressure: result must hold and no new operand may be taken.
    out_ready = 1'b0;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid) begin
      n++;
      if (n > 50) begin
        $display("FAIL valid_timeout: out_valid stayed 0 expected 1");
        $fatal(1, "valid timeout");
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = $urandom; b_x = $urandom; cin = 1'($urandom_range(0, 1));
      chk_mode = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk_mode = 0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 chk_mode = 3;
    @(negedge clk);
    @(posedge clk); #1 chk_mode = 0;
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    drain();

    // Reset during the second CALC cycle discards the operation.
    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; chk_mode = 2;
    @(negedge clk);
    @(posedge clk); #1 chk_mode = 0;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
